// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
//   - FSM state encoding (two-bit)
//   - channel count and mux-select width
//   - default data word width
package mux_scan_sequencer_pkg;

  localparam int NUM_CH     = 4;
  localparam int CTRL_W     = 2;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_next_chan_find.sv
// Finds the next enabled channel strictly above the current one.
// With from_start=1 the current channel is treated as -1, so the result is
// the lowest set mask bit.
//   mask       : channel enables
//   cur        : current channel
//   from_start : ignore cur, search from channel 0
//   nxt        : next enabled channel (0 when none)
//   none       : no qualifying channel exists
module mux_scan_sequencer_next_chan_find
  import mux_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CTRL_W-1:0] cur,
  input  logic              from_start,
  output logic [CTRL_W-1:0] nxt,
  output logic              none
);

  // Walk downward so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        nxt  = CTRL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Control stage ahead of a registered 4:1 mux. On an accepted start it
// snapshots the four source words, then steps the mux select through the
// enabled channels, holding each for a programmable dwell. A one-stage tag
// pipeline marks the cycle in which the mux output carries the final-dwell
// word of each channel.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : scan request (accepted only in IDLE)
//   i_dwell             : cycles per channel, 0 behaves as 1
//   i_chan_mask         : channel enables
//   i_data_0..3         : source words
//   o_data_0..3         : snapshot words feeding the mux
//   o_ctrl              : mux select
//   o_busy / o_done     : scanning / one-cycle end pulse
//   o_sample_valid/_ch  : mux output valid and its channel tag
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [NUM_CH-1:0]  i_chan_mask,
  input  logic [DATA_W-1:0]  i_data_0,
  input  logic [DATA_W-1:0]  i_data_1,
  input  logic [DATA_W-1:0]  i_data_2,
  input  logic [DATA_W-1:0]  i_data_3,
  output logic [DATA_W-1:0]  o_data_0,
  output logic [DATA_W-1:0]  o_data_1,
  output logic [DATA_W-1:0]  o_data_2,
  output logic [DATA_W-1:0]  o_data_3,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sample_valid,
  output logic [CTRL_W-1:0]  o_sample_ch
);

  localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

  state_t                         state_q, state_d;
  logic [DWELL_W-1:0]             cnt_q, cnt_d;
  logic [DWELL_W-1:0]             dwell_q, dwell_eff;
  logic [NUM_CH-1:0]              mask_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  snap_q;
  logic [CTRL_W-1:0]              ctrl_q, ctrl_d;
  logic                           accept;
  logic                           sample_valid_q;
  logic [CTRL_W-1:0]              sample_ch_q;

  logic [CTRL_W-1:0] first_ch, next_ch;
  logic              first_none, next_none;

  assign dwell_eff = (i_dwell == '0) ? DW_ONE : i_dwell;

  // Lowest enabled channel of the incoming mask, used at start.
  mux_scan_sequencer_next_chan_find u_first (
    .mask       (i_chan_mask),
    .cur        ('0),
    .from_start (1'b1),
    .nxt        (first_ch),
    .none       (first_none)
  );

  // Next enabled channel above the current select, from the latched mask.
  mux_scan_sequencer_next_chan_find u_next (
    .mask       (mask_q),
    .cur        (ctrl_q),
    .from_start (1'b0),
    .nxt        (next_ch),
    .none       (next_none)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          accept = 1'b1;
          if (!first_none) begin
            ctrl_d  = first_ch;
            cnt_d   = dwell_eff - DW_ONE;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DW_ONE;
        end else if (next_none) begin
          // Select holds on the last channel through DONE and IDLE.
          state_d = ST_DONE;
        end else begin
          ctrl_d = next_ch;
          cnt_d  = dwell_q - DW_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dwell_q        <= '0;
      mask_q         <= '0;
      snap_q         <= '0;
      ctrl_q         <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      if (accept) begin
        snap_q[0] <= i_data_0;
        snap_q[1] <= i_data_1;
        snap_q[2] <= i_data_2;
        snap_q[3] <= i_data_3;
        mask_q    <= i_chan_mask;
        dwell_q   <= dwell_eff;
      end
      // Tag lines up with the mux's registered output one cycle later.
      sample_valid_q <= (state_q == ST_SCAN) && (cnt_q == '0);
      sample_ch_q    <= ctrl_q;
    end
  end

  assign o_data_0       = snap_q[0];
  assign o_data_1       = snap_q[1];
  assign o_data_2       = snap_q[2];
  assign o_data_3       = snap_q[3];
  assign o_ctrl         = ctrl_q;
  assign o_busy         = (state_q == ST_SCAN);
  assign o_done         = (state_q == ST_DONE);
  assign o_sample_valid = sample_valid_q;
  assign o_sample_ch    = sample_ch_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed scenarios plus randomized scans,
// checked against a schedule model built from the channel list and dwell.
module tb_mux_scan_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start;
  logic [3:0]  i_dwell, i_chan_mask;
  logic [15:0] i_data_0, i_data_1, i_data_2, i_data_3;
  logic [15:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic [1:0]  o_ctrl, o_sample_ch;
  logic        o_busy, o_done, o_sample_valid;

  mux_scan_sequencer #(.DATA_W(16), .DWELL_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_dwell(i_dwell),
    .i_chan_mask(i_chan_mask),
    .i_data_0(i_data_0), .i_data_1(i_data_1), .i_data_2(i_data_2), .i_data_3(i_data_3),
    .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_data_3(o_data_3),
    .o_ctrl(o_ctrl), .o_busy(o_busy), .o_done(o_done),
    .o_sample_valid(o_sample_valid), .o_sample_ch(o_sample_ch)
  );

  always #5 i_clk = ~i_clk;

  // Downstream registered 4:1 mux.
  logic [15:0] mux_q;
  always @(posedge i_clk) begin
    case (o_ctrl)
      2'd0: mux_q <= o_data_0;
      2'd1: mux_q <= o_data_1;
      2'd2: mux_q <= o_data_2;
      default: mux_q <= o_data_3;
    endcase
  end

  int tests = 0;
  int fails = 0;
  int step  = 0;
  int cyc   = 0;

  logic [1:0]  exp_ctrl;
  logic [15:0] snap [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s step=%0d cyc=%0d got=%0h want=%0h", tag, step, cyc, obs, exp);
    end
  endtask

  task automatic chk_data();
    chk("data0", 32'(o_data_0), 32'(snap[0]));
    chk("data1", 32'(o_data_1), 32'(snap[1]));
    chk("data2", 32'(o_data_2), 32'(snap[2]));
    chk("data3", 32'(o_data_3), 32'(snap[3]));
  endtask

  // Called at a negedge with the DUT in IDLE. Returns at the negedge of the
  // following IDLE cycle (the re-accept cycle when hold=1).
  task automatic run_scan(input logic [3:0] mask, input logic [3:0] dwell,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input bit hold);
    int eff, len, pos, ech;
    int seq [$];
    bit ev;
    step++;
    eff = (dwell == 4'd0) ? 1 : int'(dwell);
    seq = {};
    for (int c = 0; c < 4; c++)
      if (mask[c])
        for (int r = 0; r < eff; r++) seq.push_back(c);
    len = seq.size();
    i_chan_mask = mask; i_dwell = dwell; i_start = 1'b1;
    i_data_0 = d0; i_data_1 = d1; i_data_2 = d2; i_data_3 = d3;
    snap[0] = d0; snap[1] = d1; snap[2] = d2; snap[3] = d3;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge i_clk);
      cyc = k;
      if (k == 1 && !hold) i_start = 1'b0;
      if (k <= len) exp_ctrl = 2'(seq[k-1]);
      pos = k - 1;
      ev  = (pos >= 1) && (pos <= len) && (pos % eff == 0);
      ech = ev ? seq[pos-1] : 0;
      chk("busy",  32'(o_busy), 32'(k <= len));
      chk("done",  32'(o_done), 32'(k == len + 1));
      chk("ctrl",  32'(o_ctrl), 32'(exp_ctrl));
      chk("valid", 32'(o_sample_valid), 32'(ev));
      if (ev) begin
        chk("tag_ch", 32'(o_sample_ch), 32'(ech));
        chk("mux_out", 32'(mux_q), 32'(snap[ech]));
      end
      chk_data();
      // Source words wander while busy; the snapshot must not follow.
      if (k <= len + 1) begin
        i_data_0 = (k == 2) ? 16'hB : 16'($urandom);
        i_data_1 = 16'($urandom);
        i_data_2 = 16'($urandom);
        i_data_3 = 16'($urandom);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_dwell = '0; i_chan_mask = '0;
    i_data_0 = '0; i_data_1 = '0; i_data_2 = '0; i_data_3 = '0;
    exp_ctrl = '0;
    for (int i = 0; i < 4; i++) snap[i] = '0;
    i_start = 1'b1; i_chan_mask = 4'hF; i_data_0 = 16'h1234;
    repeat (3) @(negedge i_clk);

    // Reset state, with start asserted to confirm reset priority.
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_done",  32'(o_done), 32'd0);
    chk("rst_ctrl",  32'(o_ctrl), 32'd0);
    chk("rst_valid", 32'(o_sample_valid), 32'd0);
    chk("rst_ch",    32'(o_sample_ch), 32'd0);
    chk_data();
    i_rst = 1'b0; i_start = 1'b0; i_data_0 = '0;
    @(negedge i_clk);

    // Full mask, dwell 1.
    run_scan(4'b1111, 4'd1, 16'h0, 16'hF, 16'h5, 16'h8, 1'b0);
    // Sparse mask, dwell 3.
    run_scan(4'b1010, 4'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    // Empty mask: straight to DONE.
    run_scan(4'b0000, 4'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0);
    // Dwell 0 behaves as dwell 1.
    run_scan(4'b1111, 4'd0, 16'h0, 16'hF, 16'h5, 16'h8, 1'b0);

    // Reset in the middle of a scan.
    step++;
    i_chan_mask = 4'hF; i_dwell = 4'd1; i_start = 1'b1;
    i_data_0 = 16'h9; i_data_1 = 16'h7; i_data_2 = 16'h6; i_data_3 = 16'h3;
    @(negedge i_clk); cyc = 1; i_start = 1'b0;
    @(negedge i_clk); cyc = 2;
    chk("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk); cyc = 3;
    exp_ctrl = '0;
    for (int i = 0; i < 4; i++) snap[i] = '0;
    chk("mrst_busy",  32'(o_busy), 32'd0);
    chk("mrst_done",  32'(o_done), 32'd0);
    chk("mrst_ctrl",  32'(o_ctrl), 32'd0);
    chk("mrst_valid", 32'(o_sample_valid), 32'd0);
    chk("mrst_ch",    32'(o_sample_ch), 32'd0);
    chk_data();
    i_rst = 1'b0;
    @(negedge i_clk); cyc = 4;
    chk("post_done",  32'(o_done), 32'd0);
    chk("post_busy",  32'(o_busy), 32'd0);
    chk("post_valid", 32'(o_sample_valid), 32'd0);
    run_scan(4'b0110, 4'd2, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b0);

    // Start held high: back-to-back scans, DONE every 4 cycles.
    for (int n = 0; n < 3; n++)
      run_scan(4'b0001, 4'd2, 16'(16'h50 + n), 16'h1, 16'h2, 16'h3, 1'b1);
    i_start = 1'b0;
    @(negedge i_clk);

    // Randomized scans.
    for (int n = 0; n < 12; n++) begin
      run_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)));
    end
    i_start = 1'b0;
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the registered 4:1 16-bit mux (i_data_0..3, i_ctrl, i_clk → o_data, one-cycle latency).
- On a start request, snapshots four source words, then steps the mux select through the enabled channels, holding each for a programmable dwell.
- Emits a valid/channel tag aligned with the mux's registered output, so the downstream consumer knows which channel o_data carries.

Parameters:
- DATA_W, 16, width of each data word.
- DWELL_W, 4, width of the dwell-count input.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  scan request; sampled only in IDLE.
- i_dwell  in  DWELL_W  cycles per channel; 0 is treated as 1.
- i_chan_mask  in  4  channel enables; bit n enables channel n.
- i_data_0..i_data_3  in  DATA_W each  source words.
- o_data_0..o_data_3  out  DATA_W each  snapshot words, wired to the mux data inputs.
- o_ctrl  out  2  mux select.
- o_busy  out  1  high while in SCAN.
- o_done  out  1  one-cycle pulse at scan end.
- o_sample_valid  out  1  mux output is valid for o_sample_ch this cycle.
- o_sample_ch  out  2  channel carried by the mux output.

Behaviour:
- Reset: every output is 0, state is IDLE, internal counters and latched mask/dwell are 0. Reset takes priority over all other inputs.
- Reset mid-scan: at the next edge everything returns to reset values. No o_done pulse is generated.
- States: IDLE, SCAN, DONE; two-bit encoding.
- IDLE:
  - i_start=1 loads o_data_n ← i_data_n and latches the mask and effective dwell (max(i_dwell,1)).
  - If mask ≠ 0: o_ctrl ← lowest set bit, dwell counter ← dwell−1, go to SCAN.
  - If mask = 0: go directly to DONE; no channel is sampled.
- SCAN:
  - o_busy=1.
  - Counter > 0: decrement; o_ctrl holds.
  - Counter = 0: o_ctrl ← next higher set mask bit and counter reloads; if no higher bit is set, go to DONE.
  - i_start is ignored.
- DONE: o_done=1 for exactly this cycle, o_busy=0, then go to IDLE. i_start is ignored in DONE.
- o_ctrl holds its last value in IDLE and DONE.
- Tag pipeline (registered every cycle):
  - o_sample_valid ← (state==SCAN && counter==0).
  - o_sample_ch ← o_ctrl.
  - Result: exactly one valid pulse per enabled channel, issued in the cycle the mux presents that channel's final-dwell word.
- Snapshot registers change only on an accepted start. Changes on i_data_n while busy have no effect.
- Latency, full mask, dwell 1:
  - Start sampled at edge 0.
  - o_ctrl = 0,1,2,3 in cycles 1–4; o_busy high in cycles 1–4.
  - o_sample_valid high in cycles 2–5 with o_sample_ch = 0..3.
  - o_done in cycle 5.
- Back-to-back: i_start held high re-arms in the cycle after DONE (first accept in IDLE).

Decomposition:
- Shared package:
  - State encoding constants (ST_IDLE=0, ST_SCAN=1, ST_DONE=2).
  - NUM_CH=4, CTRL_W=2.
  - DATA_W default.
- Sub-module next_chan_find (combinational):
  - Inputs: mask, current channel.
  - Outputs: next higher set channel, plus a none flag.
  - Also used with "current = −1" semantics (lowest set bit) at start.
- Everything else stays in the top: FSM, counter, snapshot, tag pipeline.

Test Plan:
- Data 0x0/0xF/0x5/0x8, mask 4'b1111, dwell 1, start pulse at edge 0 → o_ctrl 0,1,2,3 in cycles 1–4; mux o_data 0x0,0xF,0x5,0x8 with o_sample_valid and o_sample_ch 0..3 in cycles 2–5; o_done in cycle 5 only.
- Mask 4'b1010, dwell 3 → o_ctrl=1 for 3 cycles then 3 for 3 cycles; two valid pulses (ch1 at cycle 4, ch3 at cycle 7); o_done at cycle 7.
- Mask 4'b0000, start → no o_busy, no valid pulse; o_done one cycle after start.
- Dwell 0 vs 1 → identical waveforms. Change i_data_0 from 0x0 to 0xB mid-scan → mux still returns 0x0 for channel 0.
- Assert i_rst during SCAN (cycle 2) → next cycle all outputs 0; no o_done; a new start afterwards runs normally.
- i_start held high continuously, mask 4'b0001, dwell 2 → repeated scans; o_done every 4 cycles; start ignored while busy.
